// File: rtl/fetch_queue_unit_pkg.sv
// Shared types and helpers for the instruction fetch queue unit.
// Queue entries are fixed at FETCH_XLEN bits per field.
package fetch_pkg;

   localparam int FETCH_XLEN  = 32;
   localparam int INSTR_ALIGN = 2;

   typedef struct packed {
      logic [FETCH_XLEN-1:0] pc;
      logic [FETCH_XLEN-1:0] instr;
      logic [FETCH_XLEN-1:0] pc_ret;
   } fetch_entry_t;

   // Width able to hold 0..depth inclusive.
   function automatic int credit_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fetch_queue_unit_if.sv
// Redirect, instruction-memory and decode-side signals of the fetch unit.
// Signal names carry the fetch unit's own point of view (o_ driven by it).
interface fetch_queue_unit_if
   import fetch_pkg::*;
#(
   parameter int XLEN  = FETCH_XLEN,
   parameter int DEPTH = 4
);

   logic                       i_redirect_valid;
   logic [XLEN-1:0]            i_redirect_addr;
   logic                       o_im_req_valid;
   logic                       i_im_req_ready;
   logic [XLEN-1:0]            o_im_raddr;
   logic                       i_im_rsp_valid;
   logic [XLEN-1:0]            i_im_rdata;
   logic                       o_if_valid;
   logic                       i_if_ready;
   logic [XLEN-1:0]            o_if_instr;
   logic [XLEN-1:0]            o_if_pc;
   logic [XLEN-1:0]            o_if_pc_ret;
   logic [credit_w(DEPTH)-1:0] o_inflight;

   modport master (
      input  i_redirect_valid, i_redirect_addr,
      output o_im_req_valid, o_im_raddr,
      input  i_im_req_ready, i_im_rsp_valid, i_im_rdata,
      output o_if_valid, o_if_instr, o_if_pc, o_if_pc_ret, o_inflight,
      input  i_if_ready
   );

   modport slave (
      output i_redirect_valid, i_redirect_addr,
      input  o_im_req_valid, o_im_raddr,
      output i_im_req_ready, i_im_rsp_valid, i_im_rdata,
      input  o_if_valid, o_if_instr, o_if_pc, o_if_pc_ret, o_inflight,
      output i_if_ready
   );

endinterface

// File: rtl/fetch_queue_unit_queue.sv
// Circular buffer of fetched instructions with push, pop, flush and occupancy.
// The head is read combinationally and reads as zero while empty.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
)
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  fetch_entry_t               push_data,
   output fetch_entry_t               head,
   output logic [credit_w(DEPTH)-1:0] count
);

   localparam int CW = credit_w(DEPTH);
   localparam int PW = $clog2(DEPTH);

   fetch_entry_t  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          empty;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   // A full queue still accepts a push when the head leaves in the same cycle.
   assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
   assign head    = empty ? '0 : mem[rd_ptr];

   // Entry storage.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch stage: owns the PC, issues credit-limited requests to instruction memory,
// buffers in-order responses for decode and discards stale responses after a redirect.
module fetch_queue_unit
   import fetch_pkg::*;
#(
   parameter int              XLEN     = FETCH_XLEN,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
)
(
   input  logic               clk,
   input  logic               rst,
   fetch_queue_unit_if.master bus
);

   localparam int CW = credit_w(DEPTH);

   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] rsp_pc;
   logic [XLEN-1:0] redirect_pc;
   logic [CW-1:0]   inflight;
   logic [CW-1:0]   drop_cnt;
   logic [CW-1:0]   count;
   logic [CW:0]     credit_use;
   logic            req_fire;
   logic            rsp_dec;
   logic            rsp_keep;
   logic            if_pop;
   fetch_entry_t    push_data;
   fetch_entry_t    head;

   assign redirect_pc = {bus.i_redirect_addr[XLEN-1:INSTR_ALIGN], {INSTR_ALIGN{1'b0}}};

   // Requests to be dropped need no slot, so only live requests plus queued entries use credit.
   assign credit_use = {1'b0, inflight} - {1'b0, drop_cnt} + {1'b0, count};

   assign bus.o_im_req_valid = !rst && !bus.i_redirect_valid && (credit_use < (CW+1)'(DEPTH));
   assign bus.o_im_raddr     = fetch_pc;
   assign req_fire           = bus.o_im_req_valid && bus.i_im_req_ready;
   assign rsp_dec            = bus.i_im_rsp_valid && (inflight != '0);
   assign rsp_keep           = bus.i_im_rsp_valid && !bus.i_redirect_valid && (drop_cnt == '0);
   assign if_pop             = bus.o_if_valid && bus.i_if_ready && !bus.i_redirect_valid;

   assign push_data = '{pc: rsp_pc, instr: bus.i_im_rdata, pc_ret: rsp_pc + XLEN'(4)};

   assign bus.o_if_valid  = (count != '0);
   assign bus.o_if_pc     = head.pc;
   assign bus.o_if_instr  = head.instr;
   assign bus.o_if_pc_ret = head.pc_ret;
   assign bus.o_inflight  = inflight;

   // PC tracking, outstanding-request count and stale-response drop count.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
         rsp_pc   <= RESET_PC;
         inflight <= '0;
         drop_cnt <= '0;
      end else begin
         inflight <= inflight + CW'(req_fire) - CW'(rsp_dec);
         if (bus.i_redirect_valid) begin
            fetch_pc <= redirect_pc;
            rsp_pc   <= redirect_pc;
            drop_cnt <= inflight - CW'(rsp_dec);
         end else begin
            if (req_fire) begin
               fetch_pc <= fetch_pc + XLEN'(4);
            end
            if (rsp_keep) begin
               rsp_pc <= rsp_pc + XLEN'(4);
            end
            if (bus.i_im_rsp_valid && (drop_cnt != '0)) begin
               drop_cnt <= drop_cnt - CW'(1);
            end
         end
      end
   end

   fetch_queue #(
      .DEPTH (DEPTH)
   ) u_queue (
      .clk       (clk),
      .rst       (rst),
      .push      (rsp_keep),
      .pop       (if_pop),
      .flush     (bus.i_redirect_valid),
      .push_data (push_data),
      .head      (head),
      .count     (count)
   );

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Scoreboard bench: memory model tags each request with a redirect epoch; live responses
// become expected decode entries, checked by a separate monitor as decode consumes them.
module tb_fetch_queue_unit;
   import fetch_pkg::*;

   localparam int          XLEN  = 32;
   localparam int          DEPTH = 4;
   localparam logic [31:0] RPC   = 32'h0000_0100;

   typedef struct {
      logic [31:0] addr;
      int          epoch;
      int          due;
   } req_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   fetch_queue_unit_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

   fetch_queue_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   req_t         pending[$];
   fetch_entry_t exp_q[$];
   req_t         cur_req;
   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;
   int           lat = 1;
   int           epoch = 0;
   int           stale = 0;
   int           fires = 0;
   int           pops = 0;
   logic [31:0]  next_addr = RPC;
   logic         prev_wait = 1'b0;
   logic [31:0]  prev_addr = 32'h0;
   logic         live;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Drive one cycle of stimulus; memory returns the oldest request once its latency has elapsed.
   task automatic step(input logic r, input logic rd, input logic [31:0] ra,
                       input logic qr, input logic dr);
      @(posedge clk);
      #1;
      cyc++;
      rst                  = r;
      bus.i_redirect_valid = rd;
      bus.i_redirect_addr  = ra;
      bus.i_im_req_ready   = qr;
      bus.i_if_ready       = dr;
      if (pending.size() != 0 && pending[0].due <= cyc) begin
         bus.i_im_rsp_valid = 1'b1;
         bus.i_im_rdata     = mem_data(pending[0].addr);
      end else begin
         bus.i_im_rsp_valid = 1'b0;
         bus.i_im_rdata     = 32'h0;
      end
   endtask

   // Monitor: occupancy, outstanding count and head contents against the scoreboard.
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         chk("if_valid", 32'(bus.o_if_valid), 32'(exp_q.size() != 0));
         chk("inflight", 32'(bus.o_inflight), 32'(pending.size()));
         if (bus.o_if_valid && bus.i_if_ready && exp_q.size() != 0) begin
            chk("head_pc", bus.o_if_pc, exp_q[0].pc);
            chk("head_instr", bus.o_if_instr, exp_q[0].instr);
            chk("head_pc_ret", bus.o_if_pc_ret, exp_q[0].pc_ret);
            if (!bus.i_redirect_valid) begin
               void'(exp_q.pop_front());
               pops++;
            end
         end
      end
   end

   // Reference model: request addresses, epochs, drops and expected decode entries.
   initial forever begin
      @(negedge clk);
      #1;
      if (rst) begin
         chk("req_valid_in_reset", 32'(bus.o_im_req_valid), 32'd0);
         pending.delete();
         exp_q.delete();
         epoch++;
         next_addr = RPC;
         prev_wait = 1'b0;
      end else begin
         if (bus.i_im_rsp_valid) begin
            chk("rsp_has_request", 32'(pending.size() != 0), 32'd1);
            if (pending.size() != 0) begin
               cur_req = pending.pop_front();
               live    = (cur_req.epoch == epoch) && !bus.i_redirect_valid;
               if (live) begin
                  exp_q.push_back('{pc: cur_req.addr, instr: mem_data(cur_req.addr),
                                    pc_ret: cur_req.addr + 32'd4});
               end else begin
                  stale++;
               end
            end
         end
         if (bus.i_redirect_valid) begin
            chk("req_valid_on_redirect", 32'(bus.o_im_req_valid), 32'd0);
            exp_q.delete();
            epoch++;
            next_addr = {bus.i_redirect_addr[31:2], 2'b00};
            prev_wait = 1'b0;
         end else begin
            if (prev_wait) begin
               chk("req_hold_valid", 32'(bus.o_im_req_valid), 32'd1);
               chk("req_hold_addr", bus.o_im_raddr, prev_addr);
            end
            if (bus.o_im_req_valid && bus.i_im_req_ready) begin
               chk("req_addr", bus.o_im_raddr, next_addr);
               pending.push_back('{addr: bus.o_im_raddr, epoch: epoch, due: cyc + lat});
               next_addr = next_addr + 32'd4;
               fires++;
            end
            prev_wait = bus.o_im_req_valid && !bus.i_im_req_ready;
            prev_addr = bus.o_im_raddr;
         end
      end
   end

   initial begin
      int p0;
      int f0;
      int s0;
      bus.i_redirect_valid = 1'b0;
      bus.i_redirect_addr  = 32'h0;
      bus.i_im_req_ready   = 1'b0;
      bus.i_im_rsp_valid   = 1'b0;
      bus.i_im_rdata       = 32'h0;
      bus.i_if_ready       = 1'b0;

      // Reset, then streaming with a single-cycle memory.
      repeat (3) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      #7;
      chk("rst_if_valid", 32'(bus.o_if_valid), 32'd0);
      chk("rst_inflight", 32'(bus.o_inflight), 32'd0);
      chk("rst_if_pc", bus.o_if_pc, 32'h0);
      chk("rst_if_instr", bus.o_if_instr, 32'h0);
      chk("rst_if_pc_ret", bus.o_if_pc_ret, 32'h0);
      chk("first_raddr", bus.o_im_raddr, RPC);
      p0 = pops;
      repeat (19) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      #7;
      chk("throughput_pops", 32'(pops - p0), 32'd18);

      // Decode stall: exactly DEPTH requests, then fetch stops.
      step(1'b0, 1'b1, 32'h0000_0400, 1'b1, 1'b0);
      #7;
      f0 = fires;
      repeat (12) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      #7;
      chk("stall_fires", 32'(fires - f0), 32'd4);
      chk("stall_req_valid", 32'(bus.o_im_req_valid), 32'd0);
      chk("stall_head_pc", bus.o_if_pc, 32'h0000_0400);
      repeat (10) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

      // Three-cycle memory, redirect with three requests in flight.
      lat = 3;
      step(1'b0, 1'b1, 32'h0000_1000, 1'b1, 1'b1);
      repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      #7;
      s0 = stale;
      step(1'b0, 1'b1, 32'h0000_2003, 1'b1, 1'b1);
      #7;
      chk("redir_inflight", 32'(bus.o_inflight), 32'd3);
      repeat (5) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      #7;
      chk("redir_stale", 32'(stale - s0), 32'd3);
      chk("redir_drained", 32'(bus.o_inflight), 32'd0);
      chk("redir_raddr", bus.o_im_raddr, 32'h0000_2000);
      repeat (10) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

      // Redirect coinciding with a response and a pop while two entries are queued.
      repeat (4) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      lat = 1;
      step(1'b0, 1'b1, 32'h0000_3000, 1'b0, 1'b0);
      repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 32'h0000_3100, 1'b1, 1'b1);
      #7;
      chk("combo_if_valid", 32'(bus.o_if_valid), 32'd1);
      chk("combo_rsp", 32'(bus.i_im_rsp_valid), 32'd1);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      #7;
      chk("combo_flushed", 32'(bus.o_if_valid), 32'd0);
      chk("combo_raddr", bus.o_im_raddr, 32'h0000_3100);

      // Ready held low, then address wrap.
      step(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b1);
      repeat (5) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      #7;
      chk("hold_raddr", bus.o_im_raddr, 32'hFFFF_FFFC);
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      #7;
      chk("wrap_raddr", bus.o_im_raddr, 32'h0000_0000);
      repeat (8) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

      // Reset with requests in flight and entries queued; memory forgets pending reads.
      lat = 3;
      step(1'b0, 1'b1, 32'h0000_5000, 1'b1, 1'b0);
      repeat (5) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      #7;
      chk("prerst_inflight", 32'(bus.o_inflight), 32'd2);
      chk("prerst_if_valid", 32'(bus.o_if_valid), 32'd1);
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      #7;
      chk("postrst_if_valid", 32'(bus.o_if_valid), 32'd0);
      chk("postrst_inflight", 32'(bus.o_inflight), 32'd0);
      chk("postrst_if_pc", bus.o_if_pc, 32'h0);
      chk("postrst_raddr", bus.o_im_raddr, RPC);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         if (i % 250 == 0) begin
            lat = $urandom_range(1, 3);
         end
         step($urandom_range(0, 399) == 0, $urandom_range(0, 29) == 0, $urandom,
              $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
      end
      repeat (20) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      #7;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
